// File: rtl/fuzzificador_t2_seq.sv
// Sequential interval type-2 trapezoid fuzzifier sharing one restoring divider.
// Optional macro FUZZ_ROUND_EN selects round-half-up grades instead of truncation.
module fuzzificador_t2_seq #(
   parameter int WIDTH = 8,
   parameter int N_MF  = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cfg_we,
   input  logic [$clog2(8*N_MF)-1:0] cfg_addr,
   input  logic [WIDTH-1:0]          cfg_data,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          entrada,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [N_MF*WIDTH-1:0]     mf_up,
   output logic [N_MF*WIDTH-1:0]     mf_low,
   output logic [N_MF-1:0]           ativo,
   output logic                      erro_cfg
);
   localparam int NP = 8*N_MF;
   localparam int NF = 2*N_MF;
   localparam int AW = $clog2(NP);
   localparam int FW = $clog2(NF+1);
   localparam int CW = $clog2(WIDTH+1);
   localparam logic [WIDTH-1:0] FS = {WIDTH{1'b1}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state_reg, state_next;

   logic [WIDTH-1:0] pt_reg [NP];
   logic [WIDTH-1:0] x_reg;
   logic [FW-1:0]    fidx_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] rem_reg, num_low_reg, div_reg, quo_reg;
   logic             skip_reg, err_reg;
   logic [WIDTH-1:0] up_buf_reg  [N_MF];
   logic [WIDTH-1:0] low_buf_reg [N_MF];
   logic [WIDTH-1:0] mf_up_reg   [N_MF];
   logic [WIDTH-1:0] mf_low_reg  [N_MF];
   logic [N_MF-1:0]  ativo_reg;
   logic             erro_cfg_reg;

   logic             commit;
   assign commit = (fidx_reg == FW'(NF));

   // ---------------- state register / next state / outputs ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (in_valid) state_next = CALC;
         CALC:    if (commit) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE);
   end

   // ---------------- classify the current function ----------------
   logic [FW-1:0]      fidx_sel;
   logic [AW-1:0]      base;
   logic [WIDTH-1:0]   pa, pb, pc, pd;
   logic               ld_bad, ld_zero, ld_rise, ld_flat, ld_fall, ld_sat;
   logic [WIDTH-1:0]   ld_diff, ld_div;
   logic [2*WIDTH-1:0] ld_prod;
   logic [2*WIDTH:0]   ld_num;

   always_comb begin
      fidx_sel = commit ? '0 : fidx_reg;
      base     = AW'(fidx_sel) << 2;
      pa       = pt_reg[base];
      pb       = pt_reg[base | AW'(1)];
      pc       = pt_reg[base | AW'(2)];
      pd       = pt_reg[base | AW'(3)];
      ld_bad   = (pa > pb) || (pb > pc) || (pc > pd);
      ld_zero  = ld_bad || (x_reg <= pa);
      ld_rise  = !ld_zero && (x_reg < pb);
      ld_flat  = !ld_zero && !ld_rise && (x_reg <= pc);
      ld_fall  = !ld_zero && !ld_rise && !ld_flat && (x_reg < pd);
      ld_diff  = ld_rise ? (x_reg - pa) : (pd - x_reg);
      ld_div   = ld_rise ? (pb - pa) : (pd - pc);
      ld_prod  = (2*WIDTH)'(FS) * (2*WIDTH)'(ld_diff);
`ifdef FUZZ_ROUND_EN
      ld_num   = {1'b0, ld_prod} + (2*WIDTH+1)'(ld_div >> 1);
`else
      ld_num   = {1'b0, ld_prod};
`endif
      // a high half not below the divisor means the quotient would not fit
      ld_sat   = ld_num[2*WIDTH] || (ld_num[2*WIDTH-1:WIDTH] >= ld_div);
   end

   // ---------------- one restoring divide step ----------------
   logic [WIDTH:0]   trial;
   logic             q_bit;
   logic [WIDTH-1:0] rem_step, quo_step;

   always_comb begin
      trial    = {rem_reg, num_low_reg[WIDTH-1]};
      q_bit    = (trial >= {1'b0, div_reg});
      rem_step = q_bit ? WIDTH'(trial - {1'b0, div_reg}) : trial[WIDTH-1:0];
      quo_step = skip_reg ? quo_reg : {quo_reg[WIDTH-2:0], q_bit};
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NP; i++) pt_reg[i] <= '0;
         for (int i = 0; i < N_MF; i++) begin
            up_buf_reg[i]  <= '0;
            low_buf_reg[i] <= '0;
            mf_up_reg[i]   <= '0;
            mf_low_reg[i]  <= '0;
         end
         x_reg        <= '0;
         fidx_reg     <= '0;
         cnt_reg      <= '0;
         rem_reg      <= '0;
         num_low_reg  <= '0;
         div_reg      <= '0;
         quo_reg      <= '0;
         skip_reg     <= 1'b0;
         err_reg      <= 1'b0;
         ativo_reg    <= '0;
         erro_cfg_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (cfg_we && (int'(cfg_addr) < NP))
                  pt_reg[cfg_addr] <= cfg_data;
               if (in_valid) begin
                  x_reg        <= entrada;
                  fidx_reg     <= '0;
                  cnt_reg      <= '0;
                  err_reg      <= 1'b0;
                  erro_cfg_reg <= 1'b0;
               end
            end
            CALC: begin
               if (commit) begin
                  for (int i = 0; i < N_MF; i++) begin
                     mf_up_reg[i]  <= up_buf_reg[i];
                     mf_low_reg[i] <= low_buf_reg[i];
                     ativo_reg[i]  <= |up_buf_reg[i];
                  end
                  erro_cfg_reg <= err_reg;
               end else if (cnt_reg == '0) begin
                  // constant and saturated results still spend WIDTH idle steps
                  err_reg <= err_reg | ld_bad;
                  cnt_reg <= CW'(1);
                  if ((ld_rise || ld_fall) && !ld_sat) begin
                     skip_reg    <= 1'b0;
                     rem_reg     <= ld_num[2*WIDTH-1:WIDTH];
                     num_low_reg <= ld_num[WIDTH-1:0];
                     div_reg     <= ld_div;
                     quo_reg     <= '0;
                  end else begin
                     skip_reg <= 1'b1;
                     quo_reg  <= (ld_rise || ld_fall || ld_flat) ? FS : '0;
                  end
               end else begin
                  rem_reg     <= rem_step;
                  num_low_reg <= num_low_reg << 1;
                  quo_reg     <= quo_step;
                  if (cnt_reg == CW'(WIDTH)) begin
                     cnt_reg  <= '0;
                     fidx_reg <= fidx_reg + FW'(1);
                     if (fidx_reg[0]) low_buf_reg[fidx_reg[FW-1:1]] <= quo_step;
                     else             up_buf_reg[fidx_reg[FW-1:1]]  <= quo_step;
                  end else begin
                     cnt_reg <= cnt_reg + CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- output packing ----------------
   generate
      for (genvar gi = 0; gi < N_MF; gi++) begin : g_pack
         assign mf_up[gi*WIDTH +: WIDTH]  = mf_up_reg[gi];
         assign mf_low[gi*WIDTH +: WIDTH] = mf_low_reg[gi];
         assign ativo[gi]                 = ativo_reg[gi];
      end
   endgenerate

   assign erro_cfg = erro_cfg_reg;

endmodule

// File: tb/tb_fuzzificador_t2_seq.sv
// Directed bench for fuzzificador_t2_seq: vector table plus handshake, hold,
// malformed-config and mid-computation reset sequences.
module tb_fuzzificador_t2_seq;
   localparam int WIDTH = 8;
   localparam int N_MF  = 3;
`ifdef FUZZ_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif
   localparam logic [7:0] Q127 = RND ? 8'd128 : 8'd127;
   localparam logic [7:0] Q178 = RND ? 8'd179 : 8'd178;
   localparam logic [7:0] Q72  = RND ? 8'd73  : 8'd72;
   localparam logic [7:0] Q63  = RND ? 8'd64  : 8'd63;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  cfg_we;
   logic [4:0]            cfg_addr;
   logic [WIDTH-1:0]      cfg_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      entrada;
   logic                  out_valid;
   logic                  out_ready;
   logic [N_MF*WIDTH-1:0] mf_up;
   logic [N_MF*WIDTH-1:0] mf_low;
   logic [N_MF-1:0]       ativo;
   logic                  erro_cfg;

   fuzzificador_t2_seq #(.WIDTH(WIDTH), .N_MF(N_MF)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .in_valid(in_valid), .in_ready(in_ready),
      .entrada(entrada), .out_valid(out_valid), .out_ready(out_ready),
      .mf_up(mf_up), .mf_low(mf_low), .ativo(ativo), .erro_cfg(erro_cfg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  x;
      logic [23:0] up;
      logic [23:0] low;
      logic [2:0]  act;
      logic        err;
   } vec_t;

   vec_t       tbl [12];
   logic [7:0] cfg_vals [24];
   int         n_vec = 0;
   int         n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cfg_write(input int a, input logic [7:0] d);
      cfg_we   = 1'b1;
      cfg_addr = 5'(a);
      cfg_data = d;
      @(negedge clk);
      cfg_we   = 1'b0;
   endtask

   // Handshake one sample and return the cycle count until out_valid is seen.
   task automatic run_sample(input logic [7:0] x, input bit poke, output int lat);
      int guard;
      guard = 0;
      while (!in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready_before_sample", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      entrada  = x;
      @(posedge clk);
      lat = 0;
      while (lat <= 200) begin
         @(negedge clk);
         in_valid = 1'b0;
         if (poke) begin
            cfg_we   = (lat == 5);
            cfg_addr = '0;
            cfg_data = 8'd24;
         end
         if (out_valid) break;
         @(posedge clk);
         lat++;
      end
      cfg_we = 1'b0;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_after_ack", 32'({in_ready, out_valid}), 32'b10);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  lat;
      bit  seen;

      cfg_vals = '{8'd10, 8'd20, 8'd30, 8'd40,  8'd15, 8'd22, 8'd28, 8'd35,
                   8'd50, 8'd60, 8'd70, 8'd80,  8'd55, 8'd62, 8'd68, 8'd75,
                   8'd100, 8'd150, 8'd200, 8'd250, 8'd120, 8'd160, 8'd190, 8'd230};
      tbl[0]  = '{8'd15,  {8'd0, 8'd0, Q127},    24'd0,                 3'b001, 1'b0};
      tbl[1]  = '{8'd25,  {8'd0, 8'd0, 8'd255},  {8'd0, 8'd0, 8'd255},  3'b001, 1'b0};
      tbl[2]  = '{8'd10,  24'd0,                 24'd0,                 3'b000, 1'b0};
      tbl[3]  = '{8'd40,  24'd0,                 24'd0,                 3'b000, 1'b0};
      tbl[4]  = '{8'd35,  {8'd0, 8'd0, Q127},    24'd0,                 3'b001, 1'b0};
      tbl[5]  = '{8'd65,  {8'd0, 8'd255, 8'd0},  {8'd0, 8'd255, 8'd0},  3'b010, 1'b0};
      tbl[6]  = '{8'd57,  {8'd0, Q178, 8'd0},    {8'd0, Q72, 8'd0},     3'b010, 1'b0};
      tbl[7]  = '{8'd130, {8'd153, 8'd0, 8'd0},  {Q63, 8'd0, 8'd0},     3'b100, 1'b0};
      tbl[8]  = '{8'd220, {8'd153, 8'd0, 8'd0},  {Q63, 8'd0, 8'd0},     3'b100, 1'b0};
      tbl[9]  = '{8'd255, 24'd0,                 24'd0,                 3'b000, 1'b0};
      tbl[10] = '{8'd0,   24'd0,                 24'd0,                 3'b000, 1'b0};
      tbl[11] = '{8'd33,  {8'd0, 8'd0, Q178},    {8'd0, 8'd0, Q72},     3'b001, 1'b0};

      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      in_valid = 1'b0; entrada = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_handshake", 32'({in_ready, out_valid}), 32'b10);
      check("reset_grades", 32'({ativo, erro_cfg}), 32'd0);
      check("reset_mf_up", 32'(mf_up), 32'd0);
      check("reset_mf_low", 32'(mf_low), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 24; i++) cfg_write(i, cfg_vals[i]);

      // Latency, config write dropped during CALC, and DONE hold with ignored in_valid
      run_sample(8'd15, 1'b1, lat);
      check("latency_x15", 32'(lat), 32'd55);
      for (int k = 0; k < 20; k++) begin
         in_valid = k[0];
         entrada  = 8'd200;
         @(negedge clk);
         check("done_hold", 32'({out_valid, in_ready, ativo, mf_up}),
               32'({1'b1, 1'b0, 3'b001, 8'd0, 8'd0, Q127}));
      end
      in_valid = 1'b0;
      check("done_hold_low", 32'(mf_low), 32'd0);
      consume();

      for (int i = 0; i < 12; i++) begin
         run_sample(tbl[i].x, 1'b0, lat);
         check("vec_latency", 32'(lat), 32'd55);
         check("vec_mf_up", 32'(mf_up), 32'(tbl[i].up));
         check("vec_mf_low", 32'(mf_low), 32'(tbl[i].low));
         check("vec_ativo", 32'(ativo), 32'(tbl[i].act));
         check("vec_erro_cfg", 32'(erro_cfg), 32'(tbl[i].err));
         $display("vec %0d: entrada=%0d mf_up=%h mf_low=%h ativo=%b erro_cfg=%b",
                  i, tbl[i].x, mf_up, mf_low, ativo, erro_cfg);
         consume();
      end

      // Malformed MF1 LOW (A=50 > B=40), then repaired
      cfg_write(12, 8'd50);
      cfg_write(13, 8'd40);
      run_sample(8'd57, 1'b0, lat);
      check("bad_mf_low", 32'(mf_low), 32'd0);
      check("bad_mf_up", 32'(mf_up), 32'({8'd0, Q178, 8'd0}));
      check("bad_erro_cfg", 32'({ativo, erro_cfg}), 32'({3'b010, 1'b1}));
      $display("malformed: mf_low=%h erro_cfg=%b", mf_low, erro_cfg);
      consume();
      cfg_write(12, 8'd55);
      cfg_write(13, 8'd62);
      run_sample(8'd57, 1'b0, lat);
      check("fixed_mf_low", 32'(mf_low), 32'({8'd0, Q72, 8'd0}));
      check("fixed_erro_cfg", 32'(erro_cfg), 32'd0);
      $display("repaired: mf_low=%h erro_cfg=%b", mf_low, erro_cfg);
      consume();

      // Reset asserted in the 20th cycle of CALC
      in_valid = 1'b1;
      entrada  = 8'd25;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midreset_handshake", 32'({in_ready, out_valid, ativo, erro_cfg}), 32'b100000);
      check("midreset_mf_up", 32'(mf_up), 32'd0);
      check("midreset_mf_low", 32'(mf_low), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (80) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("midreset_no_pulse", 32'(seen), 32'd0);
      check("midreset_idle", 32'(in_ready), 32'd1);
      $display("mid-calc reset: in_ready=%b out_valid_seen=%b", in_ready, seen);

      // Point registers were cleared by reset, so every grade is zero
      run_sample(8'd25, 1'b0, lat);
      check("post_reset_latency", 32'(lat), 32'd55);
      check("post_reset_grades", 32'({ativo, mf_up}), 32'd0);
      consume();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
